// File: rtl/mac_rx_fcs_check_pkg.sv
// Shared constants and types for the receive FCS checker.
// Includes CRC-32 constants, status bit positions and FSM states.
package mac_rx_fcs_check_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [47:0] MAC_BCAST       = 48'hFFFF_FFFF_FFFF;

   localparam int ST_CRC  = 0;
   localparam int ST_RUNT = 1;
   localparam int ST_OVER = 2;
   localparam int ST_DST  = 3;

   localparam int LEN_W = 11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_PASS
   } state_t;

endpackage

// File: rtl/mac_rx_fcs_check_if.sv
// Byte stream in from the MAC and FCS-stripped stream out.
// master: upstream MAC side; slave: the checker.
interface mac_rx_fcs_check_if;

   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       rx_sof_i;
   logic       rx_eof_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       sof_o;
   logic       eof_o;
   logic [3:0] status_o;

   modport master (
      output rx_data_i, rx_valid_i, rx_sof_i, rx_eof_i,
      input  data_o, valid_o, sof_o, eof_o, status_o
   );

   modport slave (
      input  rx_data_i, rx_valid_i, rx_sof_i, rx_eof_i,
      output data_o, valid_o, sof_o, eof_o, status_o
   );

endinterface

// File: rtl/mac_rx_fcs_check_crc32_byte_refl.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
// Shared between the RX checker and the TX FCS generator.
module crc32_byte_refl
   import mac_rx_fcs_check_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc;
      for (int i = 0; i < 8; i++) begin
         w_c = (w_c >> 1) ^ (CRC32_POLY_REFL & {32{w_c[0] ^ i_data[i]}});
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/mac_rx_fcs_check.sv
// RX CRC-32 / length checker: strips FCS via a 4-byte delay line,
// tags the last payload byte with status and counts good/bad frames.
module mac_rx_fcs_check
   import mac_rx_fcs_check_pkg::*;
#(
   parameter int          MIN_LEN  = 64,
   parameter int          MAX_LEN  = 1518,
   parameter logic [47:0] MAC_ADDR = 48'h0012_3456_7890,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_rx_fcs_check_if.slave bus,
   output logic [CNT_W-1:0]  good_cnt_o,
   output logic [CNT_W-1:0]  bad_cnt_o
);

   state_t           r_state, w_state_nx;
   logic [2:0]       r_fill, w_fill_nx;
   logic [3:0][7:0]  r_dly;
   logic [31:0]      r_crc, w_crc_in, w_crc_nx;
   logic [LEN_W-1:0] r_len, w_len_nx;
   logic             r_uc, r_bc, w_uc_nx, w_bc_nx;
   logic             r_first;
   logic [7:0]       w_mac_b, w_bc_b;
   logic [3:0]       w_status;
   logic             w_sof, w_eof, w_take, w_rel;
   logic             w_abort, w_end, w_good, w_bad_end;
   logic             r_valid, r_sof, r_eof;
   logic [7:0]       r_data;
   logic [3:0]       r_status;
   logic [CNT_W-1:0] r_good, r_bad;

   assign w_sof   = bus.rx_valid_i & bus.rx_sof_i;
   assign w_eof   = bus.rx_valid_i & bus.rx_eof_i;
   assign w_take  = w_sof | (bus.rx_valid_i & (r_state != S_IDLE));
   assign w_rel   = bus.rx_valid_i & ~bus.rx_sof_i & (r_state == S_PASS);
   assign w_abort = w_sof & (r_state != S_IDLE);
   assign w_end   = w_take & w_eof;

   assign w_crc_in = w_sof ? CRC32_INIT : r_crc;
   assign w_len_nx = w_sof ? LEN_W'(1) : (&r_len ? r_len : r_len + 1'b1);

   crc32_byte_refl u_crc (
      .i_crc  (w_crc_in),
      .i_data (bus.rx_data_i),
      .o_crc  (w_crc_nx)
   );

   // Destination bytes 1..6 are matched as they stream past.
   always_comb begin
      w_mac_b = '0;
      w_bc_b  = '0;
      for (int k = 1; k <= 6; k++) begin
         if (w_len_nx == LEN_W'(k)) begin
            w_mac_b = MAC_ADDR[8*(6-k) +: 8];
            w_bc_b  = MAC_BCAST[8*(6-k) +: 8];
         end
      end
   end

   assign w_uc_nx = (w_sof | r_uc) &
                    ((w_len_nx > LEN_W'(6)) | (bus.rx_data_i == w_mac_b));
   assign w_bc_nx = (w_sof | r_bc) &
                    ((w_len_nx > LEN_W'(6)) | (bus.rx_data_i == w_bc_b));

   always_comb begin
      w_status          = '0;
      w_status[ST_CRC]  = (w_crc_nx != CRC32_RESIDUE);
      w_status[ST_RUNT] = (w_len_nx < LEN_W'(MIN_LEN));
      w_status[ST_OVER] = (w_len_nx > LEN_W'(MAX_LEN));
      w_status[ST_DST]  = (w_uc_nx | w_bc_nx) & (w_len_nx >= LEN_W'(6));
   end

   assign w_good    = w_rel & w_eof & (w_status[2:0] == 3'b000);
   assign w_bad_end = w_end & ~w_good;

   always_comb begin
      w_state_nx = r_state;
      w_fill_nx  = r_fill;
      if (w_sof) begin
         w_state_nx = bus.rx_eof_i ? S_IDLE : S_FILL;
         w_fill_nx  = 3'd1;
      end else if (bus.rx_valid_i) begin
         unique case (r_state)
            S_FILL: begin
               w_fill_nx = r_fill + 3'd1;
               if (bus.rx_eof_i)       w_state_nx = S_IDLE;
               else if (r_fill == 3'd3) w_state_nx = S_PASS;
            end
            S_PASS: if (bus.rx_eof_i) w_state_nx = S_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_fill  <= w_fill_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly    <= '0;
         r_crc    <= CRC32_INIT;
         r_len    <= '0;
         r_uc     <= 1'b0;
         r_bc     <= 1'b0;
         r_first  <= 1'b0;
         r_valid  <= 1'b0;
         r_sof    <= 1'b0;
         r_eof    <= 1'b0;
         r_data   <= '0;
         r_status <= '0;
         r_good   <= '0;
         r_bad    <= '0;
      end else begin
         r_valid  <= 1'b0;
         r_sof    <= 1'b0;
         r_eof    <= 1'b0;
         r_status <= '0;
         if (w_take) begin
            r_crc <= w_crc_nx;
            r_len <= w_len_nx;
            r_uc  <= w_uc_nx;
            r_bc  <= w_bc_nx;
            r_dly <= {r_dly[2:0], bus.rx_data_i};
         end
         if (w_sof) r_first <= 1'b1;
         if (w_rel) begin
            r_valid <= 1'b1;
            r_data  <= r_dly[3];
            r_sof   <= r_first;
            r_first <= 1'b0;
            r_eof   <= bus.rx_eof_i;
            if (bus.rx_eof_i) r_status <= w_status;
         end
         r_good <= r_good + CNT_W'(w_good);
         r_bad  <= r_bad + CNT_W'(w_abort) + CNT_W'(w_bad_end);
      end
   end

   assign bus.data_o   = r_data;
   assign bus.valid_o  = r_valid;
   assign bus.sof_o    = r_sof;
   assign bus.eof_o    = r_eof;
   assign bus.status_o = r_status;
   assign good_cnt_o   = r_good;
   assign bad_cnt_o    = r_bad;

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Directed bench for mac_rx_fcs_check: frames with bench-computed FCS,
// output stream captured on the falling edge and checked per frame.
module tb_mac_rx_fcs_check;

   localparam logic [47:0] MAC   = 48'h0012_3456_7890;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER = 48'h0200_0000_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] good_cnt, bad_cnt;

   always #5 clk = ~clk;

   mac_rx_fcs_check_if bus ();

   mac_rx_fcs_check dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .good_cnt_o (good_cnt),
      .bad_cnt_o  (bad_cnt)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] fr[$];
   logic [7:0] exp_q[$];
   logic [7:0] out_q[$];
   int         sof_n, eof_n, eof_idx;
   logic [7:0] sof_byte;
   logic [3:0] st;
   logic [7:0] arp_body [28];

   always @(negedge clk) begin
      if (bus.valid_o) begin
         if (bus.sof_o) begin
            sof_n++;
            sof_byte = bus.data_o;
         end
         if (bus.eof_o) begin
            eof_n++;
            eof_idx = out_q.size();
            st = bus.status_o;
         end
         out_q.push_back(bus.data_o);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      out_q.delete();
      sof_n = 0;
      eof_n = 0;
      eof_idx = -1;
      sof_byte = '0;
      st = '0;
   endtask

   function automatic logic [31:0] fcs_of(input logic [7:0] f[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (f[i]) begin
         c ^= {24'h0, f[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic append_fcs(input logic [31:0] delta);
      logic [31:0] c;
      c = fcs_of(fr) + delta;
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
   endtask

   task automatic build(input logic [47:0] dst, input logic [15:0] et,
                        input int n);
      logic [47:0] src;
      src = 48'hE091_F5B4_06B0;
      fr.delete();
      for (int k = 0; k < 6; k++) fr.push_back(dst[47-8*k -: 8]);
      for (int k = 0; k < 6; k++) fr.push_back(src[47-8*k -: 8]);
      fr.push_back(et[15:8]);
      fr.push_back(et[7:0]);
      for (int i = 14; i < n; i++) fr.push_back(8'(i * 7 + 3));
   endtask

   task automatic build_arp();
      build(BCAST, 16'h0806, 14);
      for (int i = 0; i < 28; i++) fr.push_back(arp_body[i]);
      while (fr.size() < 60) fr.push_back(8'h00);
   endtask

   task automatic exp_add(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(fr[i]);
   endtask

   task automatic send(input int n, input bit gap, input bit with_eof);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = fr[i];
         bus.rx_sof_i   = (i == 0);
         bus.rx_eof_i   = with_eof && (i == n - 1);
         if (gap && (i % 2 == 1) && (i != n - 1)) begin
            repeat (3) begin
               @(negedge clk);
               bus.rx_valid_i = 1'b0;
               bus.rx_sof_i   = 1'b1;
               bus.rx_eof_i   = 1'b1;
               bus.rx_data_i  = 8'($urandom);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      bus.rx_sof_i   = 1'b0;
      bus.rx_eof_i   = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input int n, input int sofs,
                          input int eofs, input logic [3:0] status);
      int mism;
      chk({tag, "_len"}, out_q.size(), n);
      chk({tag, "_sofs"}, sof_n, sofs);
      chk({tag, "_eofs"}, eof_n, eofs);
      if (eofs > 0) begin
         chk({tag, "_status"}, st, status);
         chk({tag, "_eofpos"}, eof_idx, n - 1);
      end
      mism = 0;
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= out_q.size() || out_q[i] !== exp_q[i]) mism++;
      chk({tag, "_data_mism"}, mism, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      arp_body = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                   8'hE0, 8'h91, 8'hF5, 8'hB4, 8'h06, 8'hB0,
                   8'hC0, 8'hA8, 8'h01, 8'h0A,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'hC0, 8'hA8, 8'h01, 8'h01};
      bus.rx_valid_i = 1'b0;
      bus.rx_sof_i   = 1'b0;
      bus.rx_eof_i   = 1'b0;
      bus.rx_data_i  = 8'h00;
      clr_mon();
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_eof", bus.eof_o, 0);
      chk("rst_status", bus.status_o, 0);
      chk("rst_good", good_cnt, 0);
      chk("rst_bad", bad_cnt, 0);
      rst_n = 1'b1;
      idle(2);

      // Good broadcast ARP
      build_arp();
      append_fcs(0);
      exp_q.delete();
      exp_add(60);
      clr_mon();
      send(64, 0, 1);
      idle(4);
      chk_out("arp", 60, 1, 1, 4'b1000);
      chk("arp_sofbyte", sof_byte, 8'hFF);
      chk("arp_good", good_cnt, 1);
      chk("arp_bad", bad_cnt, 0);

      // Same ARP with corrupted FCS
      build_arp();
      append_fcs(1);
      clr_mon();
      send(64, 0, 1);
      idle(4);
      chk_out("arpbad", 60, 1, 1, 4'b1001);
      chk("arpbad_good", good_cnt, 1);
      chk("arpbad_bad", bad_cnt, 1);

      // Runt, unicast to our address
      build(MAC, 16'h0800, 46);
      append_fcs(0);
      exp_q.delete();
      exp_add(46);
      clr_mon();
      send(50, 0, 1);
      idle(4);
      chk_out("runt", 46, 1, 1, 4'b1010);
      chk("runt_good", good_cnt, 1);
      chk("runt_bad", bad_cnt, 2);

      // Minimum-length frame with input gaps, foreign destination
      build(OTHER, 16'h0800, 60);
      append_fcs(0);
      exp_q.delete();
      exp_add(60);
      clr_mon();
      send(64, 1, 1);
      idle(4);
      chk_out("gaps", 60, 1, 1, 4'b0000);
      chk("gaps_good", good_cnt, 2);
      chk("gaps_bad", bad_cnt, 2);

      // Abort after 20 bytes, then a good 64-byte frame
      build(BCAST, 16'h0800, 60);
      exp_q.delete();
      exp_add(16);
      clr_mon();
      send(20, 0, 0);
      build(OTHER, 16'h0801, 60);
      append_fcs(0);
      exp_add(60);
      send(64, 0, 1);
      idle(4);
      chk_out("abort", 76, 2, 1, 4'b0000);
      chk("abort_good", good_cnt, 3);
      chk("abort_bad", bad_cnt, 3);

      // 4-byte frame
      fr = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_q.delete();
      clr_mon();
      send(4, 0, 1);
      idle(4);
      chk_out("four", 0, 0, 0, 4'b0000);
      chk("four_bad", bad_cnt, 4);

      // sof and eof on the same byte
      fr = '{8'h55};
      clr_mon();
      send(1, 0, 1);
      idle(4);
      chk_out("one", 0, 0, 0, 4'b0000);
      chk("one_bad", bad_cnt, 5);
      chk("one_good", good_cnt, 3);

      // Oversize by one byte, forwarded in full
      build(MAC, 16'h0800, 1515);
      append_fcs(0);
      exp_q.delete();
      exp_add(1515);
      clr_mon();
      send(1519, 0, 1);
      idle(4);
      chk_out("over", 1515, 1, 1, 4'b1100);
      chk("over_good", good_cnt, 3);
      chk("over_bad", bad_cnt, 6);

      // Reset mid-frame
      build(BCAST, 16'h0800, 60);
      append_fcs(0);
      send(30, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.rx_valid_i = 1'b0;
      bus.rx_sof_i   = 1'b0;
      bus.rx_eof_i   = 1'b0;
      #1;
      chk("mrst_valid", bus.valid_o, 0);
      chk("mrst_data", bus.data_o, 0);
      chk("mrst_good", good_cnt, 0);
      chk("mrst_bad", bad_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_mon();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.rx_valid_i = 1'b1;
         bus.rx_sof_i   = 1'b0;
         bus.rx_eof_i   = (i == 4);
         bus.rx_data_i  = 8'(8'hA0 + i);
      end
      idle(3);
      exp_q.delete();
      exp_add(60);
      send(64, 0, 1);
      idle(4);
      chk_out("post", 60, 1, 1, 4'b1000);
      chk("post_good", good_cnt, 1);
      chk("post_bad", bad_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_rx_fcs_check.md
Name: mac_rx_fcs_check

Overview:
- Sits directly downstream of mac_rgmii, in the mac_rx_clk_o domain.
- Consumes the received byte stream (preamble/SFD already removed, FCS still attached) and checks CRC-32 and frame length.
- Strips the 4 FCS bytes and forwards the frame with a per-frame status word on the last byte.
- Keeps good/bad frame counters for the status path.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.
- MAC_ADDR, 48'h0012_3456_7890, station address used for the destination-match flag.
- CNT_W, 32, width of the frame counters.

Ports:
- clk  in  1  byte clock (mac_rx_clk_o).
- rst_n  in  1  asynchronous active-low reset.
- rx_data_i  in  8  byte from MAC.
- rx_valid_i  in  1  byte strobe.
- rx_sof_i  in  1  first byte of frame; qualified by rx_valid_i.
- rx_eof_i  in  1  last byte of frame (last FCS byte); qualified by rx_valid_i.
- data_o  out  8  forwarded byte.
- valid_o  out  1  forwarded byte strobe.
- sof_o  out  1  first forwarded byte.
- eof_o  out  1  last payload byte (FCS removed).
- status_o  out  4  {dst_match, oversize, runt, crc_err}; valid only with eof_o.
- good_cnt_o  out  CNT_W  frames ending with status_o[2:0]==0.
- bad_cnt_o  out  CNT_W  all other terminated or aborted frames.

Behaviour:
- Reset (rst_n=0, async):
  - all outputs 0, counters 0;
  - delay line empty, state IDLE, CRC reg 0xFFFFFFFF.
- Input gaps:
  - rx_valid_i may drop for any number of cycles mid-frame.
  - No state advances while it is low.
  - sof/eof are ignored when rx_valid_i=0.
- CRC:
  - reflected CRC-32, poly 0xEDB88320, LSB-first, init 0xFFFFFFFF, no final XOR inside the checker.
  - Computed over every byte, FCS included.
  - Frame is CRC-good iff the next-state value including the eof byte equals residue 0xDEBB20E3.
  - The eof byte is folded in combinationally, so the result is available in the eof cycle.
- Delay line: 4-byte shift register; a byte is released only once 4 newer bytes of the same frame have arrived.
- States:
  - IDLE –(valid&sof)→ FILL.
  - FILL: counts 1..4 accepted bytes, nothing is output; 4th byte → PASS.
  - PASS: each accepted byte releases the oldest byte.
  - eof in FILL or PASS → IDLE.
- Output timing:
  - Outputs are registered; a released byte appears 1 cycle after the accepting input cycle.
  - sof_o accompanies the first released byte.
  - At input eof, the released byte is the last payload byte: eof_o=1 and status_o is valid in that cycle.
- Length: byte counter is 11 bits and saturates at 2047.
  - runt = len < MIN_LEN.
  - oversize = len > MAX_LEN.
  - Oversize frames are still forwarded in full; there is no truncation.
- dst_match: set when bytes 1..6 equal MAC_ADDR or FF:FF:FF:FF:FF:FF. It is informational only and does not affect the counters.
- Frames of ≤4 bytes: nothing is output; bad_cnt increments.
- sof while in FILL or PASS (abort):
  - pending delay-line bytes are discarded;
  - bad_cnt increments;
  - no eof_o is emitted for the aborted frame;
  - the new sof starts a fresh frame in the same cycle.
- sof and eof in the same cycle: 1-byte frame, treated as ≤4 bytes.
- Counters wrap modulo 2^CNT_W and update 1 cycle after the eof/abort cycle.
- rst_n asserted mid-frame: everything clears immediately. A frame arriving after release is accepted only from its sof. Stray bytes without sof are ignored in IDLE.

Decomposition:
- mac_pkg: CRC32_POLY_REFL, CRC32_RESIDUE, broadcast MAC constant, status bit index localparams.
- One sub-module, crc32_byte_refl: combinational next-CRC for one byte. It is reusable on the TX side.

Test Plan:
- ARP request: broadcast destination, source E0:91:F5:B4:06:B0, 60 bytes + correct FCS, no gaps → 60 bytes out, sof_o on 0xFF, eof_o on the last padding byte, status_o=4'b1000, good_cnt=1.
- Same frame with FCS+1 → identical 60-byte output, status_o=4'b1001, bad_cnt=1, good_cnt unchanged.
- 46-byte frame with correct FCS (50 total) → 46 bytes out, status_o[1]=1 (runt), bad_cnt+1.
- Test frame with rx_valid_i low for 3 cycles after every other byte → byte sequence identical to the gapless run, status_o=0 in the CRC and length bits, good_cnt+1.
- Frame aborted by a new sof after 20 bytes, followed by a good 64-byte frame → 16 bytes out without eof_o, then 60 bytes with eof_o; bad_cnt+1, good_cnt+1.
- rst_n pulsed low for 2 cycles at byte 30 → outputs 0 immediately; the next correct frame passes with good_cnt=1 and bad_cnt=0.
